// File: rtl/lsu_req_batcher.sv
// lsu_req_batcher: splits one wide LSU request (one lane per thread) into
// NUM_REQS-lane beats for the L1 dcache core-request ports. The batch index is
// appended to the tag so the response path can re-gather the lanes. Batches with
// an all-zero lane mask are skipped. A request whose mask is all zero is consumed
// without issuing any beat. The only state is the batch pointer. The beat payload
// is combinational from the held request and that pointer.
module lsu_req_batcher #(
  parameter int NUM_LANES  = 4,
  parameter int NUM_REQS   = 2,
  parameter int ADDR_WIDTH = 30,
  parameter int WORD_SIZE  = 4,
  parameter int TAG_WIDTH  = 8,
  localparam int NUM_BATCHES = (NUM_LANES + NUM_REQS - 1) / NUM_REQS,
  localparam int BSEL_BITS   = $clog2(NUM_BATCHES),
  localparam int BSEL_W      = (BSEL_BITS > 0) ? BSEL_BITS : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  input  logic                                  in_rw,
  input  logic [NUM_LANES-1:0]                  in_mask,
  input  logic [NUM_LANES*WORD_SIZE-1:0]        in_byteen,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]       in_addr,
  input  logic [NUM_LANES*WORD_SIZE*8-1:0]      in_data,
  input  logic [TAG_WIDTH-1:0]                  in_tag,
  output logic                                  in_ready,
  output logic                                  out_valid,
  output logic                                  out_rw,
  output logic [NUM_REQS-1:0]                   out_mask,
  output logic [NUM_REQS*WORD_SIZE-1:0]         out_byteen,
  output logic [NUM_REQS*ADDR_WIDTH-1:0]        out_addr,
  output logic [NUM_REQS*WORD_SIZE*8-1:0]       out_data,
  output logic [TAG_WIDTH+BSEL_BITS-1:0]        out_tag,
  output logic                                  out_last,
  input  logic                                  out_ready
);

  localparam int PAD_LANES = NUM_BATCHES * NUM_REQS;
  localparam int DATA_W    = WORD_SIZE * 8;

  // Request vectors widened to a whole number of batches; phantom lanes read as zero
  logic [PAD_LANES-1:0]            mask_pad;
  logic [PAD_LANES*WORD_SIZE-1:0]  byteen_pad;
  logic [PAD_LANES*ADDR_WIDTH-1:0] addr_pad;
  logic [PAD_LANES*DATA_W-1:0]     data_pad;

  // Per-batch bookkeeping
  logic [NUM_BATCHES-1:0] batch_nz;   // batch has at least one active lane
  logic [NUM_BATCHES-1:0] batch_elig; // non-empty and not yet issued
  logic [NUM_BATCHES-1:0] above_nz;   // some non-empty batch sits above this one

  logic [BSEL_W-1:0] batch_ptr_reg;
  logic [BSEL_W-1:0] batch_ptr_next;
  logic [BSEL_W-1:0] cur;
  logic              any;
  logic              cur_last;

  logic beat_fire;
  logic req_fire;

  genvar gi;

  // Lane padding: real lanes pass through, lanes past NUM_LANES are tied to zero
  generate
    for (gi = 0; gi < PAD_LANES; gi++) begin : g_pad
      if (gi < NUM_LANES) begin : g_real
        assign mask_pad[gi]                               = in_mask[gi];
        assign byteen_pad[gi*WORD_SIZE +: WORD_SIZE]      = in_byteen[gi*WORD_SIZE +: WORD_SIZE];
        assign addr_pad[gi*ADDR_WIDTH +: ADDR_WIDTH]      = in_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign data_pad[gi*DATA_W +: DATA_W]              = in_data[gi*DATA_W +: DATA_W];
      end else begin : g_fill
        assign mask_pad[gi]                               = 1'b0;
        assign byteen_pad[gi*WORD_SIZE +: WORD_SIZE]      = '0;
        assign addr_pad[gi*ADDR_WIDTH +: ADDR_WIDTH]      = '0;
        assign data_pad[gi*DATA_W +: DATA_W]              = '0;
      end
    end
  endgenerate

  // Batch occupancy and eligibility relative to the issue pointer
  generate
    for (gi = 0; gi < NUM_BATCHES; gi++) begin : g_batch
      assign batch_nz[gi]   = |mask_pad[gi*NUM_REQS +: NUM_REQS];
      assign batch_elig[gi] = batch_nz[gi] && (gi >= int'(batch_ptr_reg));
      if (gi == NUM_BATCHES - 1) begin : g_top
        assign above_nz[gi] = 1'b0;
      end else begin : g_below
        assign above_nz[gi] = |batch_nz[NUM_BATCHES-1:gi+1];
      end
    end
  endgenerate

  // Pick the lowest eligible batch; scanning downward lets the lowest win
  always_comb begin
    cur      = '0;
    cur_last = 1'b0;
    for (int b = NUM_BATCHES - 1; b >= 0; b--) begin
      if (batch_elig[b]) begin
        cur      = BSEL_W'(b);
        cur_last = !above_nz[b];
      end
    end
    any = |batch_elig;
  end

  // Beat payload: slice `cur` of the padded request vectors
  always_comb begin
    out_mask   = '0;
    out_byteen = '0;
    out_addr   = '0;
    out_data   = '0;
    for (int b = 0; b < NUM_BATCHES; b++) begin
      if (BSEL_W'(b) == cur) begin
        out_mask   = mask_pad[b*NUM_REQS +: NUM_REQS];
        out_byteen = byteen_pad[b*NUM_REQS*WORD_SIZE +: NUM_REQS*WORD_SIZE];
        out_addr   = addr_pad[b*NUM_REQS*ADDR_WIDTH +: NUM_REQS*ADDR_WIDTH];
        out_data   = data_pad[b*NUM_REQS*DATA_W +: NUM_REQS*DATA_W];
      end
    end
  end

  // Tag extension: batch index occupies the low bits when there is more than one batch
  generate
    if (BSEL_BITS > 0) begin : g_tag_sel
      assign out_tag = {in_tag, cur[BSEL_BITS-1:0]};
    end else begin : g_tag_plain
      assign out_tag = in_tag;
    end
  endgenerate

  assign out_rw    = in_rw;
  assign out_last  = any && cur_last;
  assign out_valid = in_valid && any;
  assign in_ready  = in_valid && (!any || (out_valid && out_ready && out_last));

  assign beat_fire = out_valid && out_ready;
  assign req_fire  = in_valid && in_ready;

  // Next pointer: rewind when the request retires, step past `cur` on an intermediate beat
  always_comb begin
    batch_ptr_next = batch_ptr_reg;
    if (req_fire) begin
      batch_ptr_next = '0;
    end else if (beat_fire && !out_last) begin
      batch_ptr_next = cur + BSEL_W'(1);
    end
  end

  // Batch pointer register; reset restarts any held request from batch 0
  always_ff @(posedge clk) begin
    if (reset) begin
      batch_ptr_reg <= '0;
    end else begin
      batch_ptr_reg <= batch_ptr_next;
    end
  end

endmodule

// File: tb/tb_lsu_req_batcher.sv
// Bench for lsu_req_batcher: directed cases then randomized requests, checked
// against a beat-list model (the ordered list of non-empty batches of a request).
module tb_lsu_req_batcher;

  localparam int NL = 4;
  localparam int NR = 2;
  localparam int AW = 30;
  localparam int WS = 4;
  localparam int TW = 8;
  localparam int NB = 2;
  localparam int DW = WS * 8;
  localparam int NL3 = 3;

  logic clk = 1'b0;
  logic reset;

  // DUT A: 4 lanes, 2 per beat
  logic                 a_in_valid, a_in_rw, a_in_ready;
  logic [NL-1:0]        a_in_mask;
  logic [NL*WS-1:0]     a_in_byteen;
  logic [NL*AW-1:0]     a_in_addr;
  logic [NL*DW-1:0]     a_in_data;
  logic [TW-1:0]        a_in_tag;
  logic                 a_out_valid, a_out_rw, a_out_last, a_out_ready;
  logic [NR-1:0]        a_out_mask;
  logic [NR*WS-1:0]     a_out_byteen;
  logic [NR*AW-1:0]     a_out_addr;
  logic [NR*DW-1:0]     a_out_data;
  logic [TW:0]          a_out_tag;

  // DUT B: 3 lanes, 2 per beat (partial final batch)
  logic                 b_in_valid, b_in_rw, b_in_ready;
  logic [NL3-1:0]       b_in_mask;
  logic [NL3*WS-1:0]    b_in_byteen;
  logic [NL3*AW-1:0]    b_in_addr;
  logic [NL3*DW-1:0]    b_in_data;
  logic [TW-1:0]        b_in_tag;
  logic                 b_out_valid, b_out_rw, b_out_last, b_out_ready;
  logic [NR-1:0]        b_out_mask;
  logic [NR*WS-1:0]     b_out_byteen;
  logic [NR*AW-1:0]     b_out_addr;
  logic [NR*DW-1:0]     b_out_data;
  logic [TW:0]          b_out_tag;

  int checks = 0;
  int failures = 0;

  // Model state: ordered list of batch indices still to be issued, and position in it
  int beats[$];
  int pos;
  logic a_hs_in, a_hs_out;

  lsu_req_batcher #(.NUM_LANES(NL), .NUM_REQS(NR), .ADDR_WIDTH(AW), .WORD_SIZE(WS), .TAG_WIDTH(TW)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_rw(a_in_rw), .in_mask(a_in_mask), .in_byteen(a_in_byteen),
    .in_addr(a_in_addr), .in_data(a_in_data), .in_tag(a_in_tag), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_rw(a_out_rw), .out_mask(a_out_mask), .out_byteen(a_out_byteen),
    .out_addr(a_out_addr), .out_data(a_out_data), .out_tag(a_out_tag), .out_last(a_out_last),
    .out_ready(a_out_ready)
  );

  lsu_req_batcher #(.NUM_LANES(NL3), .NUM_REQS(NR), .ADDR_WIDTH(AW), .WORD_SIZE(WS), .TAG_WIDTH(TW)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_rw(b_in_rw), .in_mask(b_in_mask), .in_byteen(b_in_byteen),
    .in_addr(b_in_addr), .in_data(b_in_data), .in_tag(b_in_tag), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_rw(b_out_rw), .out_mask(b_out_mask), .out_byteen(b_out_byteen),
    .out_addr(b_out_addr), .out_data(b_out_data), .out_tag(b_out_tag), .out_last(b_out_last),
    .out_ready(b_out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Beat list of a request: every batch whose lane-mask slice is non-zero, in order
  task automatic build_beats(input logic [NL-1:0] mask);
    beats.delete();
    for (int b = 0; b < NB; b++)
      if (mask[b*NR +: NR] != '0) beats.push_back(b);
    pos = 0;
  endtask

  task automatic new_req_a(input logic [NL-1:0] mask, input logic [TW-1:0] tag);
    a_in_valid = 1'b1;
    a_in_rw    = 1'($urandom());
    a_in_mask  = mask;
    a_in_tag   = tag;
    a_in_byteen = 16'($urandom());
    for (int l = 0; l < NL; l++) begin
      a_in_addr[l*AW +: AW] = 30'($urandom());
      a_in_data[l*DW +: DW] = $urandom();
    end
    build_beats(mask);
  endtask

  // Compare DUT A against the model; must be called away from the clock edge
  task automatic check_a(input string step);
    int b;
    logic exp_valid, exp_ready, exp_last;
    exp_valid = a_in_valid && (beats.size() > 0);
    exp_last  = 1'b0;
    b = 0;
    if (beats.size() > 0) begin
      b = beats[pos];
      exp_last = (pos == beats.size() - 1);
    end
    exp_ready = a_in_valid && ((beats.size() == 0) || (a_out_ready && exp_last));
    chk({step, ".out_valid"}, 64'(a_out_valid), 64'(exp_valid));
    chk({step, ".in_ready"},  64'(a_in_ready),  64'(exp_ready));
    if (exp_valid) begin
      chk({step, ".mask"},   64'(a_out_mask),   64'(a_in_mask[b*NR +: NR]));
      chk({step, ".addr"},   64'(a_out_addr),   64'(a_in_addr[b*NR*AW +: NR*AW]));
      chk({step, ".data"},   64'(a_out_data),   64'(a_in_data[b*NR*DW +: NR*DW]));
      chk({step, ".byteen"}, 64'(a_out_byteen), 64'(a_in_byteen[b*NR*WS +: NR*WS]));
      chk({step, ".tag"},    64'(a_out_tag),    64'({a_in_tag, 1'(b)}));
      chk({step, ".last"},   64'(a_out_last),   64'(exp_last));
      chk({step, ".rw"},     64'(a_out_rw),     64'(a_in_rw));
    end
    a_hs_in  = exp_ready;
    a_hs_out = exp_valid && a_out_ready;
    $display("step %s valid=%0b ready=%0b tag=0x%0h last=%0b", step, a_out_valid, a_in_ready, a_out_tag, a_out_last);
  endtask

  task automatic at_neg(input string step);
    @(negedge clk);
    check_a(step);
  endtask

  // Clock edge, then advance the model by the handshakes that were expected
  task automatic to_pos();
    @(posedge clk);
    #1;
    if (a_hs_in) begin
      a_in_valid = 1'b0;
      pos = 0;
    end else if (a_hs_out) begin
      pos++;
    end
  endtask

  initial begin
    reset = 1'b1;
    a_in_valid = 1'b0; a_in_rw = 1'b0; a_in_mask = '0; a_in_byteen = '0;
    a_in_addr = '0; a_in_data = '0; a_in_tag = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_rw = 1'b0; b_in_mask = '0; b_in_byteen = '0;
    b_in_addr = '0; b_in_data = '0; b_in_tag = '0; b_out_ready = 1'b0;
    build_beats('0);

    // Reset state with nothing presented
    @(negedge clk);
    chk("rst.a_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst.a_in_ready",  64'(a_in_ready),  64'd0);
    chk("rst.b_out_valid", 64'(b_out_valid), 64'd0);
    chk("rst.b_in_ready",  64'(b_in_ready),  64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // T1: full mask, two beats back-to-back
    new_req_a(4'b1111, 8'h5A);
    a_out_ready = 1'b1;
    at_neg("t1.b0");
    chk("t1.tag0",  64'(a_out_tag),  64'h0B4);
    chk("t1.last0", 64'(a_out_last), 64'd0);
    to_pos();
    at_neg("t1.b1");
    chk("t1.tag1",  64'(a_out_tag),  64'h0B5);
    chk("t1.last1", 64'(a_out_last), 64'd1);
    chk("t1.ready1", 64'(a_in_ready), 64'd1);
    to_pos();

    // T2: only upper batch active
    new_req_a(4'b1100, 8'h21);
    at_neg("t2.b1");
    chk("t2.tag_lsb", 64'(a_out_tag[0]), 64'd1);
    to_pos();

    // T3: empty request consumed without a beat
    new_req_a(4'b0000, 8'h33);
    at_neg("t3.empty");
    chk("t3.ready", 64'(a_in_ready), 64'd1);
    to_pos();

    // T4: backpressure on beat 0, then release
    new_req_a(4'b1111, 8'h44);
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg("t4.hold");
      to_pos();
    end
    a_out_ready = 1'b1;
    at_neg("t4.b0");
    to_pos();
    at_neg("t4.b1");
    to_pos();

    // T5: three-lane configuration, final batch half populated
    b_in_valid  = 1'b1;
    b_in_mask   = 3'b111;
    b_in_tag    = 8'h3C;
    b_in_byteen = 12'hFFF;
    b_in_addr   = {30'h100, 30'h2, 30'h1};
    b_in_data   = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    b_out_ready = 1'b1;
    @(negedge clk);
    chk("t5.b0.valid", 64'(b_out_valid), 64'd1);
    chk("t5.b0.mask",  64'(b_out_mask),  64'h3);
    chk("t5.b0.last",  64'(b_out_last),  64'd0);
    chk("t5.b0.tag",   64'(b_out_tag),   64'h078);
    chk("t5.b0.ready", 64'(b_in_ready),  64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5.b1.mask",   64'(b_out_mask),          64'h1);
    chk("t5.b1.addr0",  64'(b_out_addr[AW-1:0]),  64'h100);
    chk("t5.b1.addr1",  64'(b_out_addr[2*AW-1:AW]), 64'd0);
    chk("t5.b1.data1",  64'(b_out_data[2*DW-1:DW]), 64'd0);
    chk("t5.b1.byteen1", 64'(b_out_byteen[2*WS-1:WS]), 64'd0);
    chk("t5.b1.tag",    64'(b_out_tag),  64'h079);
    chk("t5.b1.last",   64'(b_out_last), 64'd1);
    chk("t5.b1.ready",  64'(b_in_ready), 64'd1);
    $display("step t5 b1 mask=%0b addr=0x%0h last=%0b", b_out_mask, b_out_addr, b_out_last);
    @(posedge clk); #1;
    b_in_valid = 1'b0;

    // T6: reset one cycle after beat 0 fires, request held
    new_req_a(4'b1111, 8'h5A);
    a_out_ready = 1'b1;
    at_neg("t6.b0");
    to_pos();
    reset = 1'b1;
    a_out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    pos = 0;
    a_out_ready = 1'b1;
    at_neg("t6.reissue");
    chk("t6.tag_lsb", 64'(a_out_tag[0]), 64'd0);
    to_pos();
    at_neg("t6.b1");
    to_pos();

    // Randomized traffic with random backpressure and idle gaps
    for (int c = 0; c < 400; c++) begin
      if (!a_in_valid && ($urandom_range(0, 3) != 0))
        new_req_a(4'($urandom_range(0, 15)), 8'($urandom()));
      a_out_ready = ($urandom_range(0, 3) != 0);
      at_neg($sformatf("rnd%0d", c));
      to_pos();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
